// File: rtl/pll_recfg_seq.sv
// PLL reconfiguration sequencer: issues the eight management writes for a new
// M/K/C setting, pulses pll_reset, then waits for the PLL to report lock.
module pll_recfg_seq #(
  parameter int unsigned LOCK_TIMEOUT = 5000000,
  parameter int unsigned WR_TIMEOUT   = 1024,
  parameter int unsigned RST_CYCLES   = 8
) (
  input  logic        CLK_50M,
  input  logic        RESET,
  input  logic        req,
  input  logic [31:0] req_m,
  input  logic [31:0] req_k,
  input  logic [31:0] req_c,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  output logic        pll_reset,
  input  logic        locked
);

  localparam int LW = ($clog2(LOCK_TIMEOUT + 1) < 3) ? 3 : $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = ($clog2(WR_TIMEOUT + 1) < 1) ? 1 : $clog2(WR_TIMEOUT + 1);
  localparam int RW = ($clog2(RST_CYCLES + 1) < 1) ? 1 : $clog2(RST_CYCLES + 1);

  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_BLIND = LW'(4);
  localparam logic [SW-1:0] STALL_LAST = SW'(WR_TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WRITE, GAP, PRST, LOCKWAIT, FINISH
  } state_t;

  state_t          state;
  logic [2:0]      idx;
  logic [31:0]     m_q, k_q, c_q;
  logic [SW-1:0]   stall_cnt;
  logic [RW-1:0]   rst_cnt;
  logic [LW-1:0]   lock_cnt;
  logic            lock_meta, lock_s;

  function automatic logic [5:0] wr_addr(input logic [2:0] i);
    case (i)
      3'd0:    wr_addr = 6'd0;
      3'd1:    wr_addr = 6'd4;
      3'd2:    wr_addr = 6'd7;
      3'd3:    wr_addr = 6'd3;
      3'd4:    wr_addr = 6'd5;
      3'd5:    wr_addr = 6'd9;
      3'd6:    wr_addr = 6'd8;
      default: wr_addr = 6'd2;
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [2:0] i, input logic [31:0] m,
                                          input logic [31:0] k, input logic [31:0] c);
    case (i)
      3'd1:    wr_data = m;
      3'd2:    wr_data = k;
      3'd3:    wr_data = 32'h0001_0000;
      3'd4:    wr_data = c;
      3'd5:    wr_data = 32'd1;
      3'd6:    wr_data = 32'd7;
      default: wr_data = 32'd0;
    endcase
  endfunction

  // Outputs are registered and updated on the transition into each state.
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      state          <= IDLE;
      idx            <= 3'd0;
      m_q            <= 32'd0;
      k_q            <= 32'd0;
      c_q            <= 32'd0;
      stall_cnt      <= '0;
      rst_cnt        <= '0;
      lock_cnt       <= '0;
      lock_meta      <= 1'b0;
      lock_s         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= 6'd0;
      mgmt_writedata <= 32'd0;
      pll_reset      <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            m_q            <= req_m;
            k_q            <= req_k;
            c_q            <= req_c;
            err            <= 1'b0;
            idx            <= 3'd0;
            stall_cnt      <= '0;
            busy           <= 1'b1;
            mgmt_write     <= 1'b1;
            mgmt_address   <= wr_addr(3'd0);
            mgmt_writedata <= wr_data(3'd0, req_m, req_k, req_c);
            state          <= WRITE;
          end
        end
        WRITE: begin
          if (!mgmt_waitrequest) begin
            mgmt_write     <= 1'b0;
            mgmt_address   <= 6'd0;
            mgmt_writedata <= 32'd0;
            state          <= GAP;
          end else if (stall_cnt == STALL_LAST) begin
            err            <= 1'b1;
            done           <= 1'b1;
            mgmt_write     <= 1'b0;
            mgmt_address   <= 6'd0;
            mgmt_writedata <= 32'd0;
            state          <= FINISH;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        GAP: begin
          if (idx == 3'd7) begin
            pll_reset <= 1'b1;
            rst_cnt   <= '0;
            state     <= PRST;
          end else begin
            idx            <= idx + 3'd1;
            stall_cnt      <= '0;
            mgmt_write     <= 1'b1;
            mgmt_address   <= wr_addr(idx + 3'd1);
            mgmt_writedata <= wr_data(idx + 3'd1, m_q, k_q, c_q);
            state          <= WRITE;
          end
        end
        PRST: begin
          if (rst_cnt == RST_LAST) begin
            pll_reset <= 1'b0;
            lock_cnt  <= '0;
            state     <= LOCKWAIT;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        // The first cycles after reset release are blind so a lock left over
        // from before the reset cannot end the sequence.
        LOCKWAIT: begin
          if (lock_cnt >= LOCK_BLIND && lock_s) begin
            done  <= 1'b1;
            state <= FINISH;
          end else if (lock_cnt == LOCK_LAST) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_recfg_seq.sv
// Directed bench for pll_recfg_seq: a negedge monitor checks completed writes
// against a scoreboard filled when each request is issued.
module tb_pll_recfg_seq;

  logic        CLK_50M;
  logic        RESET;
  logic        req;
  logic [31:0] req_m, req_k, req_c;
  logic        busy, done, err;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_waitrequest;
  logic        pll_reset;
  logic        locked;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [37:0] sb[$];
  int          wr_cycles[$];
  int          wr_runs[$];
  logic [37:0] mon_exp;
  int          run_len = 0;
  int          hold7 = 0;
  int          prst_cnt = 0;
  int          done_cnt = 0;
  int          last_done = 0;
  int          lw_entry = 0;
  logic        prev_prst = 1'b0;

  pll_recfg_seq #(
    .LOCK_TIMEOUT(100),
    .WR_TIMEOUT(1024),
    .RST_CYCLES(8)
  ) dut (
    .CLK_50M(CLK_50M),
    .RESET(RESET),
    .req(req),
    .req_m(req_m),
    .req_k(req_k),
    .req_c(req_c),
    .busy(busy),
    .done(done),
    .err(err),
    .mgmt_address(mgmt_address),
    .mgmt_writedata(mgmt_writedata),
    .mgmt_write(mgmt_write),
    .mgmt_waitrequest(mgmt_waitrequest),
    .pll_reset(pll_reset),
    .locked(locked)
  );

  initial CLK_50M = 1'b0;
  always #10 CLK_50M = ~CLK_50M;

  always @(posedge CLK_50M) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c);
    sb.push_back({6'd0, 32'd0});
    sb.push_back({6'd4, m});
    sb.push_back({6'd7, k});
    sb.push_back({6'd3, 32'h0001_0000});
    sb.push_back({6'd5, c});
    sb.push_back({6'd9, 32'd1});
    sb.push_back({6'd8, 32'd7});
    sb.push_back({6'd2, 32'd0});
  endtask

  task automatic step();
    @(posedge CLK_50M);
    #1;
  endtask

  // lock_mode: 0 = locked rises 20 cycles after pll_reset falls, otherwise leave locked alone
  task automatic run_seq(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c,
                         input int stall_len, input bit busy_req, input int lock_mode,
                         input bit expect_writes);
    bit seen;
    if (expect_writes) push_exp(m, k, c);
    req = 1'b1; req_m = m; req_k = k; req_c = c;
    step();
    req = 1'b0;
    check("busy_after_req", busy, 1);
    check("err_cleared_on_req", err, 0);
    if (busy_req) begin
      step(); step();
      req = 1'b1; req_m = 32'hDEAD_BEEF; req_k = 32'hCAFE_F00D; req_c = 32'h1234_5678;
      step();
      req = 1'b0;
    end
    if (stall_len > 0) begin
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        if (mgmt_write && mgmt_address == 6'd7) begin seen = 1; break; end
        step();
      end
      check("k_write_reached", seen, 1);
      mgmt_waitrequest = 1'b1;
      repeat (stall_len) step();
      mgmt_waitrequest = 1'b0;
    end
    if (lock_mode == 0) begin
      seen = 0;
      for (int i = 0; i < 3000; i++) begin
        if (pll_reset) begin seen = 1; break; end
        step();
      end
      check("pll_reset_rise", seen, 1);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        if (!pll_reset) begin seen = 1; break; end
        step();
      end
      check("pll_reset_fall", seen, 1);
      repeat (20) step();
      locked = 1'b1;
    end
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin seen = 1; break; end
      step();
    end
    check("done_seen", seen, 1);
    step();
  endtask

  // Passive monitor: write completions, bus idling, reset pulse width, done timing.
  always @(negedge CLK_50M) begin
    if (!RESET) begin
      if (mgmt_write && !mgmt_waitrequest) begin
        wr_cycles.push_back(cyc);
        check("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          check("wr_addr", mgmt_address, mon_exp[37:32]);
          check("wr_data", mgmt_writedata, mon_exp[31:0]);
        end
      end
      if (mgmt_write) run_len++;
      else if (run_len != 0) begin
        wr_runs.push_back(run_len);
        run_len = 0;
      end
      if (mgmt_write && mgmt_address == 6'd7 && mgmt_writedata == 32'h1999_999A) hold7++;
      if (!mgmt_write) check("bus_idle_zero", {mgmt_address, mgmt_writedata}, 0);
      if (pll_reset) prst_cnt++;
      if (prev_prst && !pll_reset) lw_entry = cyc;
      if (done) begin
        done_cnt++;
        last_done = cyc;
      end
    end
    prev_prst = pll_reset;
  end

  initial begin
    int p0, d0;
    RESET = 1'b1; req = 1'b0; req_m = 0; req_k = 0; req_c = 0;
    mgmt_waitrequest = 1'b0; locked = 1'b0;
    repeat (2) @(posedge CLK_50M);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_write", mgmt_write, 0);
    check("rst_addr", mgmt_address, 0);
    check("rst_data", mgmt_writedata, 0);
    check("rst_pll_reset", pll_reset, 0);
    RESET = 1'b0;
    step();

    $display("[TB] normal sequence");
    wr_cycles.delete(); p0 = prst_cnt; d0 = done_cnt;
    run_seq(32'h404, 32'h1999_999A, 32'h20504, 0, 0, 0, 1);
    check("normal_writes", wr_cycles.size(), 8);
    for (int i = 1; i < wr_cycles.size(); i++)
      check("normal_spacing", wr_cycles[i] - wr_cycles[i-1], 2);
    check("normal_prst_width", prst_cnt - p0, 8);
    check("normal_done_count", done_cnt - d0, 1);
    check("normal_err", err, 0);
    check("normal_sb_empty", sb.size(), 0);
    locked = 1'b0;

    $display("[TB] stall on K write");
    wr_cycles.delete(); wr_runs.delete(); hold7 = 0; d0 = done_cnt;
    run_seq(32'h404, 32'h1999_999A, 32'h20504, 5, 0, 0, 1);
    check("stall_hold_k", hold7, 6);
    check("stall_run_k", wr_runs.size() > 2 ? wr_runs[2] : 0, 6);
    check("stall_writes", wr_cycles.size(), 8);
    check("stall_err", err, 0);
    check("stall_done_count", done_cnt - d0, 1);
    locked = 1'b0;

    $display("[TB] write timeout");
    wr_runs.delete(); p0 = prst_cnt; d0 = done_cnt;
    mgmt_waitrequest = 1'b1;
    run_seq(32'h111, 32'h222, 32'h333, 0, 0, 2, 0);
    mgmt_waitrequest = 1'b0;
    check("wto_runs", wr_runs.size(), 1);
    check("wto_run_len", wr_runs.size() > 0 ? wr_runs[0] : 0, 1024);
    check("wto_no_prst", prst_cnt - p0, 0);
    check("wto_done_count", done_cnt - d0, 1);
    check("wto_err", err, 1);

    $display("[TB] lock timeout");
    d0 = done_cnt;
    run_seq(32'h55, 32'h66, 32'h77, 0, 0, 2, 1);
    check("lto_latency", last_done - lw_entry, 100);
    check("lto_err", err, 1);
    check("lto_done_count", done_cnt - d0, 1);
    repeat (3) step();
    check("lto_err_stable", err, 1);

    $display("[TB] good request after failure");
    run_seq(32'h404, 32'h1999_999A, 32'h20504, 0, 0, 0, 1);
    check("recover_err", err, 0);
    locked = 1'b0;

    $display("[TB] stale lock");
    locked = 1'b1;
    repeat (3) step();
    wr_cycles.delete(); p0 = prst_cnt;
    run_seq(32'hA0, 32'hB0, 32'hC0, 0, 0, 1, 1);
    check("stale_blind", (last_done - lw_entry) >= 4, 1);
    check("stale_prst_width", prst_cnt - p0, 8);
    check("stale_writes", wr_cycles.size(), 8);
    check("stale_err", err, 0);

    $display("[TB] req while busy");
    wr_cycles.delete(); d0 = done_cnt;
    run_seq(32'h1, 32'h2, 32'h3, 0, 1, 1, 1);
    check("busyreq_writes", wr_cycles.size(), 8);
    check("busyreq_sb_empty", sb.size(), 0);
    check("busyreq_done_count", done_cnt - d0, 1);
    repeat (3) step();
    check("busyreq_idle", busy, 0);
    locked = 1'b0;

    $display("[TB] reset during PRST");
    d0 = done_cnt;
    push_exp(32'h9, 32'h8, 32'h7);
    req = 1'b1; req_m = 32'h9; req_k = 32'h8; req_c = 32'h7;
    step();
    req = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
        if (pll_reset) begin seen = 1; break; end
        step();
      end
      check("rprst_reached", seen, 1);
    end
    step();
    RESET = 1'b1;
    step();
    check("rprst_pll_reset", pll_reset, 0);
    check("rprst_busy", busy, 0);
    RESET = 1'b0;
    repeat (30) step();
    check("rprst_no_done", done_cnt - d0, 0);
    check("rprst_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_recfg_seq.md
PLL_RECFG_SEQ -- requirements
Module: pll_recfg_seq

Interface
REQ-001 SHALL have parameter LOCK_TIMEOUT, default 5000000, max CLK_50M cycles to wait for lock (100 ms).
REQ-002 SHALL have parameter WR_TIMEOUT, default 1024, max cycles one management write may stall on waitrequest.
REQ-003 SHALL have parameter RST_CYCLES, default 8, width in cycles of the pll_reset pulse.
REQ-004 SHALL have ports, in this order:
- CLK_50M  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- req  in  1  start pulse, sampled in IDLE only.
- req_m  in  32  M-counter word.
- req_k  in  32  fractional K word.
- req_c  in  32  C0-counter word.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  last sequence failed.
- mgmt_address  out  6  reconfig address.
- mgmt_writedata  out  32  reconfig data.
- mgmt_write  out  1  write strobe.
- mgmt_waitrequest  in  1  reconfig stall.
- pll_reset  out  1  PLL reset.
- locked  in  1  PLL lock, asynchronous.

Function
REQ-005 SHALL pass locked through a 2-flop synchronizer before any use; lock_s denotes the synchronized value.
REQ-006 SHALL implement the states IDLE, WRITE, GAP, PRST, LOCKWAIT and FINISH.
REQ-007 In IDLE with req=1, SHALL latch req_m, req_k and req_c, clear err, set write index to 0, and enter WRITE next cycle.
REQ-008 SHALL ignore req in any state other than IDLE; there is no queueing and no abort.
REQ-009 SHALL issue exactly 8 writes, in this order (address:data):
- 0:0 (mode)
- 4:M
- 7:K
- 3:0x00010000 (N bypass)
- 5:C
- 9:1 (charge pump)
- 8:7 (bandwidth)
- 2:0 (start)
REQ-010 In WRITE, SHALL hold mgmt_write=1 with stable address and data until a cycle in which mgmt_waitrequest=0; that cycle completes the write.
REQ-011 After each completed write, SHALL enter GAP for exactly 1 cycle with mgmt_write=0.
REQ-012 From GAP, SHALL go to the next WRITE, or to PRST after index 7.
REQ-013 If a single write stalls for WR_TIMEOUT cycles, SHALL set err=1, drop mgmt_write, skip PRST, and go to FINISH.
REQ-014 In PRST, SHALL drive pll_reset=1 for exactly RST_CYCLES cycles, then enter LOCKWAIT with the lock counter cleared.
REQ-015 LOCKWAIT SHALL ignore lock_s during its first 4 cycles, so that a stale pre-reset lock is rejected.
REQ-016 After those 4 cycles, SHALL go to FINISH on the first cycle with lock_s=1, leaving err=0.
REQ-017 If the lock counter reaches LOCK_TIMEOUT with lock_s=0, SHALL set err=1 and go to FINISH.
REQ-018 In FINISH, SHALL assert done=1 for one cycle and return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE, registered, and 1 on the cycle after req is accepted.
REQ-020 err SHALL remain stable from FINISH until the next accepted req.
REQ-021 Counters SHALL be sized to hold their parameter value without wrap, and SHALL saturate rather than roll over.
REQ-022 mgmt_address and mgmt_writedata SHALL be driven only in WRITE; otherwise they are 0.

Reset
REQ-023 With RESET=1, SHALL force state IDLE and the following outputs to 0: busy, done, err, mgmt_write, mgmt_address, mgmt_writedata, pll_reset; synchronizer flops SHALL also be 0.
REQ-024 RESET mid-sequence SHALL abort immediately with no done pulse, and mgmt_write SHALL drop on the next edge.
REQ-025 RESET SHALL have priority over req in the same cycle.

Verification
REQ-026 Normal sequence: req with M=0x404, K=0x1999999A, C=0x20504, waitrequest=0, locked rising 20 cycles after pll_reset falls -> 8 writes in REQ-009 order, 2 cycles apart; pll_reset high 8 cycles; done=1, err=0.
REQ-027 Stall: waitrequest=1 for 5 cycles on the K write -> address 7 and data 0x1999999A held for 6 cycles; order unchanged; done with err=0.
REQ-028 Write timeout: waitrequest stuck at 1 -> mgmt_write drops after 1024 cycles, no pll_reset pulse, done=1, err=1.
REQ-029 Lock timeout (LOCK_TIMEOUT=100): locked held 0 -> done exactly 100 cycles into LOCKWAIT, err=1; a following good req clears err.
REQ-030 Stale lock: locked held 1 throughout -> still 8 writes and pll_reset pulse; done no earlier than 4 cycles after LOCKWAIT entry.
REQ-031 Busy req and reset: req pulsed during WRITE is ignored, giving exactly 8 writes; RESET during PRST -> pll_reset=0 and busy=0 next cycle, with no done pulse.
